board_ray_scanner: RTL and testbench
====================================

Name: board_ray_scanner

Overview:
- Parametrised successor to the fixed 2x2 square board: a BOARD_W x BOARD_W occupancy store plus a sequential ray-walk engine.
- It generates pseudo-legal sliding and king moves for one source square, one ray step per cycle.
- Moves leave on a valid/ready stream to the move-list collector.
- Sits between the board loader and the engine search controller.

Parameters:
- BOARD_W, 8, board edge length in squares (legal 2..8).
- SQ_W, clog2(BOARD_W*BOARD_W), square index width. Derived; must not be overridden.
- CNT_W, clog2(8*BOARD_W), move counter width. Derived.

Ports:
- clk  in  1  system clock, rising edge
- clear_n  in  1  asynchronous active-low reset
- wr_en  in  1  board write strobe
- wr_addr  in  SQ_W  square written; index = row*BOARD_W + col
- wr_piece  in  6  piece code: [5]=occupied, [4]=colour (1=black), [2:0]=type (3 bishop, 4 rook, 5 queen, 6 king, others non-sliding)
- start  in  1  begin scan; accepted only when busy=0
- src_sq  in  SQ_W  source square, sampled with start
- abort  in  1  synchronous scan cancel
- busy  out  1  scan in progress
- mv_valid  out  1  move available
- mv_ready  in  1  consumer accepts move
- mv_src  out  SQ_W  source square of move
- mv_dst  out  SQ_W  destination square
- mv_capture  out  1  destination holds an enemy piece
- done  out  1  one-cycle pulse at scan completion
- move_count  out  CNT_W  moves accepted in the last completed scan

Behaviour:
- Reset (clear_n=0, async):
  - all board squares = 0.
  - FSM = IDLE.
  - busy, mv_valid, done, move_count, mv_src, mv_dst, mv_capture = 0.
- Board writes: wr_en writes wr_piece to wr_addr at the clock edge. Ignored while busy=1. wr_addr >= BOARD_W*BOARD_W is ignored.
- Directions, fixed order, 0..7:
  - U = row+1
  - D = row-1
  - L = col+1
  - R = col-1
  - UL = row+1,col+1
  - UR = row+1,col-1
  - DL = row-1,col+1
  - DR = row-1,col-1
- Direction mask by type:
  - rook: 0-3
  - bishop: 4-7
  - queen/king: 0-7
  - any other type or unoccupied source: empty mask
- FSM states IDLE, FETCH, STEP, EMIT, DONE:
  - IDLE: when start=1, latch src_sq, clear the running counter, set busy=1, go to FETCH. start is ignored when busy=1.
  - FETCH (1 cycle): read the source piece, build the direction mask, set the current direction to the lowest masked direction and the cursor to src. If the mask is empty, go to DONE.
  - STEP (1 cycle per evaluation): compute the next square from the cursor.
    - Off-board (row/col wrap below 0 or at/above BOARD_W), or occupied by same colour as source: advance to the next masked direction, reset the cursor to src, stay in STEP. If no direction remains, go to DONE.
    - Otherwise register mv_dst and mv_capture (= occupied and opposite colour), set mv_valid=1, go to EMIT.
  - EMIT: hold mv_valid/mv_src/mv_dst/mv_capture stable until mv_ready=1. On acceptance:
    - increment the running counter.
    - if mv_capture=1 or type is king: advance direction.
    - else move the cursor to mv_dst.
    - return to STEP; mv_valid drops the next cycle unless re-asserted by STEP.
  - DONE (1 cycle): done=1, move_count = running counter, busy=0 next cycle, go to IDLE.
- Latency:
  - start at edge T: busy=1 from T+1.
  - the earliest mv_valid is visible in the cycle after STEP, i.e. after edge T+2.
  - with mv_ready tied high, each emitted move takes 2 cycles and each ray termination costs 1 extra STEP cycle.
- abort=1 in any non-IDLE state: next state IDLE, mv_valid=0, busy=0, no done pulse, move_count unchanged, board unchanged. abort has priority over mv_ready in the same cycle; a move presented in that cycle is not counted.
- Re-asserting clear_n low mid-scan clears everything as at reset.
- The board is stable during a scan because writes are blocked.

Test Plan (BOARD_W=4):
- Empty board, white rook (6'b100100) at sq 0, start -> moves in order 4,8,12,1,2,3, all mv_capture=0; done with move_count=6.
- White queen (6'b100101) at sq 0, black piece at sq 8, white piece at sq 2 -> moves 4, 8 (capture=1), 1, 5, 10, 15; move_count=6.
- White king (6'b100110) at sq 5, empty board -> moves 9,1,6,4,10,8,2,0 in direction order; move_count=8.
- Knight (6'b100010) or empty square at src -> no mv_valid, done two cycles after start, move_count=0.
- Rook at sq 0 with mv_ready low for 3 cycles on the first move -> mv_dst=4 held stable with mv_valid=1; accepted once, count unaffected by the stall.
- abort asserted while the second move is in EMIT -> busy=0 next cycle, no done pulse, move_count keeps the previous value; wr_en during the scan leaves the board unchanged.

Source files
------------

// File: rtl/board_ray_scanner.sv
// Square-board occupancy store plus a sequential ray-walk engine that emits
// pseudo-legal sliding/king moves for one source square, one ray step per cycle.
module board_ray_scanner #(
  parameter int unsigned  BOARD_W = 8,
  localparam int unsigned SQ_W    = $clog2(BOARD_W * BOARD_W),
  localparam int unsigned CNT_W   = $clog2(8 * BOARD_W)
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             wr_en,
  input  logic [SQ_W-1:0]  wr_addr,
  input  logic [5:0]       wr_piece,
  input  logic             start,
  input  logic [SQ_W-1:0]  src_sq,
  input  logic             abort,
  output logic             busy,
  output logic             mv_valid,
  input  logic             mv_ready,
  output logic [SQ_W-1:0]  mv_src,
  output logic [SQ_W-1:0]  mv_dst,
  output logic             mv_capture,
  output logic             done,
  output logic [CNT_W-1:0] move_count
);

  localparam int unsigned NSQ = BOARD_W * BOARD_W;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_STEP, S_EMIT, S_DONE} state_t;

  state_t           state;
  logic [5:0]       board [NSQ];
  logic [SQ_W-1:0]  src_q;
  logic [SQ_W-1:0]  cur_sq;
  logic [5:0]       src_piece;
  logic [7:0]       dir_mask;
  logic [CNT_W-1:0] run_cnt;

  logic [7:0]       fetch_mask;
  logic [7:0]       mask_rest;
  logic [2:0]       cur_dir;
  logic             step_up, step_dn, step_cp, step_cm;
  logic             off_board;
  logic [SQ_W-1:0]  nxt_sq;
  logic [5:0]       tgt_piece;
  logic             blocked;
  logic             capture;
  logic             is_king;
  int               row_i, col_i, nrow_i, ncol_i;

  // Direction mask for the piece on the source square
  always_comb begin
    fetch_mask = 8'h00;
    if (board[src_q][5]) begin
      case (board[src_q][2:0])
        3'd3:    fetch_mask = 8'hF0;
        3'd4:    fetch_mask = 8'h0F;
        3'd5,
        3'd6:    fetch_mask = 8'hFF;
        default: fetch_mask = 8'h00;
      endcase
    end
  end

  // Current ray step: lowest remaining direction applied to the cursor
  always_comb begin
    cur_dir = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (dir_mask[i]) cur_dir = 3'(i);
    end
    mask_rest = dir_mask & (dir_mask - 8'd1);
    step_up   = (cur_dir == 3'd0) || (cur_dir == 3'd4) || (cur_dir == 3'd5);
    step_dn   = (cur_dir == 3'd1) || (cur_dir == 3'd6) || (cur_dir == 3'd7);
    step_cp   = (cur_dir == 3'd2) || (cur_dir == 3'd4) || (cur_dir == 3'd6);
    step_cm   = (cur_dir == 3'd3) || (cur_dir == 3'd5) || (cur_dir == 3'd7);
    row_i     = int'(cur_sq) / int'(BOARD_W);
    col_i     = int'(cur_sq) % int'(BOARD_W);
    off_board = (step_up && (row_i == int'(BOARD_W) - 1)) || (step_dn && (row_i == 0)) ||
                (step_cp && (col_i == int'(BOARD_W) - 1)) || (step_cm && (col_i == 0));
    nrow_i    = row_i + (step_up ? 1 : 0) - (step_dn ? 1 : 0);
    ncol_i    = col_i + (step_cp ? 1 : 0) - (step_cm ? 1 : 0);
    nxt_sq    = off_board ? cur_sq : SQ_W'(nrow_i * int'(BOARD_W) + ncol_i);
    tgt_piece = board[nxt_sq];
    blocked   = off_board || (tgt_piece[5] && (tgt_piece[4] == src_piece[4]));
    capture   = tgt_piece[5] && (tgt_piece[4] != src_piece[4]);
    is_king   = (src_piece[2:0] == 3'd6);
  end

  // Board store; writes are locked out while a scan is running
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < int'(NSQ); i++) board[i] <= 6'd0;
    end else if (wr_en && !busy && (32'(wr_addr) < NSQ)) begin
      board[wr_addr] <= wr_piece;
    end
  end

  // Scan sequencer with registered stream and status outputs
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state      <= S_IDLE;
      src_q      <= '0;
      cur_sq     <= '0;
      src_piece  <= 6'd0;
      dir_mask   <= 8'h00;
      run_cnt    <= '0;
      busy       <= 1'b0;
      mv_valid   <= 1'b0;
      mv_src     <= '0;
      mv_dst     <= '0;
      mv_capture <= 1'b0;
      done       <= 1'b0;
      move_count <= '0;
    end else begin
      done <= 1'b0;
      if (abort && (state != S_IDLE)) begin
        state    <= S_IDLE;
        busy     <= 1'b0;
        mv_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              src_q   <= src_sq;
              run_cnt <= '0;
              busy    <= 1'b1;
              state   <= S_FETCH;
            end
          end
          S_FETCH: begin
            src_piece <= board[src_q];
            dir_mask  <= fetch_mask;
            cur_sq    <= src_q;
            mv_src    <= src_q;
            if (fetch_mask == 8'h00) begin
              done       <= 1'b1;
              move_count <= run_cnt;
              state      <= S_DONE;
            end else begin
              state <= S_STEP;
            end
          end
          S_STEP: begin
            if (dir_mask == 8'h00) begin
              done       <= 1'b1;
              move_count <= run_cnt;
              state      <= S_DONE;
            end else if (blocked) begin
              dir_mask <= mask_rest;
              cur_sq   <= src_q;
              if (mask_rest == 8'h00) begin
                done       <= 1'b1;
                move_count <= run_cnt;
                state      <= S_DONE;
              end
            end else begin
              mv_dst     <= nxt_sq;
              mv_capture <= capture;
              mv_valid   <= 1'b1;
              state      <= S_EMIT;
            end
          end
          S_EMIT: begin
            if (mv_ready) begin
              run_cnt  <= run_cnt + CNT_W'(1);
              mv_valid <= 1'b0;
              if (mv_capture || is_king) begin
                dir_mask <= mask_rest;
                cur_sq   <= src_q;
              end else begin
                cur_sq <= mv_dst;
              end
              state <= S_STEP;
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_board_ray_scanner.sv
// Directed self-checking bench for board_ray_scanner on a 4x4 board.
module tb_board_ray_scanner;

  localparam int unsigned BW    = 4;
  localparam int unsigned SQ_W  = 4;
  localparam int unsigned CNT_W = 5;

  logic             clk = 1'b0;
  logic             clear_n;
  logic             wr_en;
  logic [SQ_W-1:0]  wr_addr;
  logic [5:0]       wr_piece;
  logic             start;
  logic [SQ_W-1:0]  src_sq;
  logic             abort;
  logic             busy;
  logic             mv_valid;
  logic             mv_ready;
  logic [SQ_W-1:0]  mv_src;
  logic [SQ_W-1:0]  mv_dst;
  logic             mv_capture;
  logic             done;
  logic [CNT_W-1:0] move_count;

  int checks   = 0;
  int failures = 0;

  int q_dst[$];
  int q_src[$];
  int q_cap[$];
  int got_count;
  bit got_done;

  board_ray_scanner #(.BOARD_W(BW)) dut (
    .clk(clk), .clear_n(clear_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_piece(wr_piece),
    .start(start), .src_sq(src_sq), .abort(abort), .busy(busy), .mv_valid(mv_valid),
    .mv_ready(mv_ready), .mv_src(mv_src), .mv_dst(mv_dst), .mv_capture(mv_capture),
    .done(done), .move_count(move_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_sq(input int a, input logic [5:0] p);
    wr_en    = 1'b1;
    wr_addr  = 4'(a);
    wr_piece = p;
    tick();
    wr_en    = 1'b0;
  endtask

  task automatic clear_board();
    for (int i = 0; i < 16; i++) write_sq(i, 6'd0);
  endtask

  task automatic start_scan(input int s);
    src_sq = 4'(s);
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // Records accepted moves until done (or budget); no comparisons here
  task automatic collect(input int budget);
    q_dst.delete(); q_src.delete(); q_cap.delete();
    got_done  = 1'b0;
    got_count = -1;
    for (int i = 0; i < budget; i++) begin
      if (mv_valid && mv_ready) begin
        q_dst.push_back(int'(mv_dst));
        q_src.push_back(int'(mv_src));
        q_cap.push_back(int'(mv_capture));
      end
      if (done) begin
        got_done  = 1'b1;
        got_count = int'(move_count);
        break;
      end
      tick();
    end
    if (got_done) tick();
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, mv_valid, done, move_count, mv_src, mv_dst, mv_capture} !== '0) begin
      failures++;
      $display("FAIL reset_outputs busy=%b valid=%b done=%b cnt=%0d src=%0d dst=%0d cap=%b required all zero",
               busy, mv_valid, done, move_count, mv_src, mv_dst, mv_capture);
    end
    clear_n = 1'b1;
    tick();
  endtask

  task automatic test_rook_empty();
    int exp_dst[6];
    exp_dst = '{4, 8, 12, 1, 2, 3};
    clear_board();
    write_sq(0, 6'b100100);
    mv_ready = 1'b1;
    start_scan(0);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL rook_busy got=%b exp=1", busy); end
    collect(200);
    checks++;
    if (!got_done) begin failures++; $display("FAIL rook_done timeout"); end
    checks++;
    if (q_dst.size() != 6) begin failures++; $display("FAIL rook_nmoves got=%0d exp=6", q_dst.size()); end
    for (int i = 0; i < 6 && i < q_dst.size(); i++) begin
      checks++;
      if (q_dst[i] != exp_dst[i] || q_cap[i] != 0 || q_src[i] != 0) begin
        failures++;
        $display("FAIL rook_move[%0d] got dst=%0d cap=%0d src=%0d exp dst=%0d cap=0 src=0",
                 i, q_dst[i], q_cap[i], q_src[i], exp_dst[i]);
      end
    end
    checks++;
    if (got_count != 6) begin failures++; $display("FAIL rook_count got=%0d exp=6", got_count); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rook_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_queen_blocking();
    int exp_dst[6];
    int exp_cap[6];
    exp_dst = '{4, 8, 1, 5, 10, 15};
    exp_cap = '{0, 1, 0, 0, 0, 0};
    clear_board();
    write_sq(0, 6'b100101);
    write_sq(8, 6'b110001);
    write_sq(2, 6'b100001);
    mv_ready = 1'b1;
    start_scan(0);
    collect(200);
    checks++;
    if (!got_done || q_dst.size() != 6) begin
      failures++;
      $display("FAIL queen_nmoves got=%0d done=%0d exp=6", q_dst.size(), got_done);
    end
    for (int i = 0; i < 6 && i < q_dst.size(); i++) begin
      checks++;
      if (q_dst[i] != exp_dst[i] || q_cap[i] != exp_cap[i]) begin
        failures++;
        $display("FAIL queen_move[%0d] got dst=%0d cap=%0d exp dst=%0d cap=%0d",
                 i, q_dst[i], q_cap[i], exp_dst[i], exp_cap[i]);
      end
    end
    checks++;
    if (got_count != 6) begin failures++; $display("FAIL queen_count got=%0d exp=6", got_count); end
  endtask

  task automatic test_king();
    int exp_dst[8];
    exp_dst = '{9, 1, 6, 4, 10, 8, 2, 0};
    clear_board();
    write_sq(5, 6'b100110);
    mv_ready = 1'b1;
    start_scan(5);
    collect(200);
    checks++;
    if (!got_done || q_dst.size() != 8) begin
      failures++;
      $display("FAIL king_nmoves got=%0d done=%0d exp=8", q_dst.size(), got_done);
    end
    for (int i = 0; i < 8 && i < q_dst.size(); i++) begin
      checks++;
      if (q_dst[i] != exp_dst[i] || q_cap[i] != 0 || q_src[i] != 5) begin
        failures++;
        $display("FAIL king_move[%0d] got dst=%0d cap=%0d src=%0d exp dst=%0d cap=0 src=5",
                 i, q_dst[i], q_cap[i], q_src[i], exp_dst[i]);
      end
    end
    checks++;
    if (got_count != 8) begin failures++; $display("FAIL king_count got=%0d exp=8", got_count); end
  endtask

  task automatic test_empty_mask();
    int srcs[2];
    srcs = '{3, 7};
    clear_board();
    write_sq(3, 6'b100010);
    mv_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start_scan(srcs[k]);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || mv_valid !== 1'b0) begin
        failures++;
        $display("FAIL nomove_cycle1 src=%0d busy=%b done=%b valid=%b exp 1/0/0", srcs[k], busy, done, mv_valid);
      end
      tick();
      checks++;
      if (done !== 1'b1 || move_count !== 5'd0 || mv_valid !== 1'b0) begin
        failures++;
        $display("FAIL nomove_done src=%0d done=%b cnt=%0d valid=%b exp 1/0/0", srcs[k], done, move_count, mv_valid);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL nomove_idle src=%0d busy=%b done=%b exp 0/0", srcs[k], busy, done);
      end
    end
  endtask

  task automatic test_backpressure();
    int exp_dst[6];
    bit seen;
    exp_dst = '{4, 8, 12, 1, 2, 3};
    clear_board();
    write_sq(0, 6'b100100);
    mv_ready = 1'b0;
    start_scan(0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mv_valid) begin seen = 1'b1; break; end
      tick();
    end
    checks++;
    if (!seen || mv_dst !== 4'd4) begin
      failures++;
      $display("FAIL stall_first seen=%0d dst=%0d exp dst=4", seen, mv_dst);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (mv_valid !== 1'b1 || mv_dst !== 4'd4 || mv_capture !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold[%0d] valid=%b dst=%0d cap=%b exp 1/4/0", i, mv_valid, mv_dst, mv_capture);
      end
    end
    mv_ready = 1'b1;
    collect(200);
    checks++;
    if (q_dst.size() != 6) begin failures++; $display("FAIL stall_nmoves got=%0d exp=6", q_dst.size()); end
    for (int i = 0; i < 6 && i < q_dst.size(); i++) begin
      checks++;
      if (q_dst[i] != exp_dst[i]) begin
        failures++;
        $display("FAIL stall_move[%0d] got=%0d exp=%0d", i, q_dst[i], exp_dst[i]);
      end
    end
    checks++;
    if (got_count != 6) begin failures++; $display("FAIL stall_count got=%0d exp=6", got_count); end
  endtask

  task automatic test_abort();
    int n;
    bit pulsed;
    int exp_dst[6];
    exp_dst = '{4, 8, 12, 1, 2, 3};
    mv_ready = 1'b1;
    start_scan(0);
    write_sq(8, 6'b100001);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      if (mv_valid) n++;
      if (n == 2) break;
      tick();
    end
    checks++;
    if (n != 2 || mv_dst !== 4'd8) begin
      failures++;
      $display("FAIL abort_second_move seen=%0d dst=%0d exp 2/8", n, mv_dst);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || mv_valid !== 1'b0 || done !== 1'b0 || move_count !== 5'd6) begin
      failures++;
      $display("FAIL abort_state busy=%b valid=%b done=%b cnt=%0d exp 0/0/0/6", busy, mv_valid, done, move_count);
    end
    pulsed = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done || busy || mv_valid) pulsed = 1'b1;
    end
    checks++;
    if (pulsed || move_count !== 5'd6) begin
      failures++;
      $display("FAIL abort_quiet activity=%0d cnt=%0d exp 0/6", pulsed, move_count);
    end
    start_scan(0);
    collect(200);
    checks++;
    if (q_dst.size() != 6 || got_count != 6) begin
      failures++;
      $display("FAIL abort_board_nmoves got=%0d cnt=%0d exp 6/6", q_dst.size(), got_count);
    end
    for (int i = 0; i < 6 && i < q_dst.size(); i++) begin
      checks++;
      if (q_dst[i] != exp_dst[i] || q_cap[i] != 0) begin
        failures++;
        $display("FAIL abort_board_move[%0d] got dst=%0d cap=%0d exp dst=%0d cap=0", i, q_dst[i], q_cap[i], exp_dst[i]);
      end
    end
  endtask

  task automatic test_reset_midscan();
    mv_ready = 1'b1;
    start_scan(0);
    tick();
    tick();
    clear_n = 1'b0;
    #2;
    checks++;
    if (busy !== 1'b0 || mv_valid !== 1'b0 || move_count !== 5'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL midscan_reset busy=%b valid=%b cnt=%0d done=%b exp all 0", busy, mv_valid, move_count, done);
    end
    clear_n = 1'b1;
    tick();
    start_scan(0);
    collect(50);
    checks++;
    if (!got_done || q_dst.size() != 0 || got_count != 0) begin
      failures++;
      $display("FAIL midscan_board_cleared done=%0d moves=%0d cnt=%0d exp 1/0/0", got_done, q_dst.size(), got_count);
    end
  endtask

  initial begin
    clear_n  = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_piece = '0;
    start    = 1'b0;
    src_sq   = '0;
    abort    = 1'b0;
    mv_ready = 1'b0;
    #12;
    test_reset();
    test_rook_empty();
    test_queen_blocking();
    test_king();
    test_empty_mask();
    test_backpressure();
    test_abort();
    test_reset_midscan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
